// File: rtl/bmi_alu_seq_if.sv
// Request/response bundle for bmi_alu_seq: the decode side drives the request
// and out_ready, and the ALU returns the handshake flags and the result.
interface bmi_alu_seq_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            opcode;
    logic [DATA_WIDTH-1:0] A_in;
    logic [DATA_WIDTH-1:0] B_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Alu_out;
    logic                  busy;

    modport master (
        output in_valid, opcode, A_in, B_in, out_ready,
        input  in_ready, out_valid, Alu_out, busy
    );

    modport slave (
        input  in_valid, opcode, A_in, B_in, out_ready,
        output in_ready, out_valid, Alu_out, busy
    );
endinterface

// File: rtl/bmi_alu_seq.sv
// Handshaked bit-manipulation ALU: single-cycle rotates, and parity/popcount
// reduced one CHUNK_WIDTH slice per cycle so wide operands close timing.
module bmi_alu_seq #(
    parameter int DATA_WIDTH  = 256,
    parameter int CHUNK_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    bmi_alu_seq_if.slave bus
);
    localparam int AW     = $clog2(DATA_WIDTH);
    localparam int ACC_W  = AW + 1;
    localparam int N      = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IW     = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OP_PARITY = 2'b00;
    localparam logic [1:0] OP_ROTR   = 2'b01;
    localparam logic [1:0] OP_ROTL   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [AW-1:0]         amt_q, amt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;

    logic [CHUNK_WIDTH-1:0]  chunk_arr [N];
    logic [CHUNK_WIDTH-1:0]  chunk_sel;
    logic [ACC_W-1:0]        chunk_cnt;
    logic [ACC_W-1:0]        acc_sum;
    logic [2*DATA_WIDTH-1:0] dbl;
    logic [2*DATA_WIDTH-1:0] rotr_full;
    logic [2*DATA_WIDTH-1:0] rotl_full;
    logic [DATA_WIDTH-1:0]   rot_res;
    logic [DATA_WIDTH-1:0]   red_res;
    logic                    is_rotate;
    logic                    last_chunk;

    // Slice the captured operand so the reduction picks one chunk per cycle.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chunk
            assign chunk_arr[gi] = a_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
        end
    endgenerate

    always_comb begin
        chunk_sel = chunk_arr[idx_q];
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            chunk_cnt = chunk_cnt + ACC_W'(chunk_sel[i]);
        end
        acc_sum = acc_q + chunk_cnt;

        // Parity is the LSB of the population count, so both share one accumulator.
        if (op_q == OP_PARITY) begin
            red_res = {{(DATA_WIDTH-1){1'b0}}, acc_sum[0]};
        end else begin
            red_res = DATA_WIDTH'(acc_sum);
        end

        dbl       = {a_q, a_q};
        rotr_full = dbl >> amt_q;
        rotl_full = dbl << amt_q;
        if (op_q == OP_ROTR) begin
            rot_res = rotr_full[DATA_WIDTH-1:0];
        end else begin
            rot_res = rotl_full[2*DATA_WIDTH-1:DATA_WIDTH];
        end

        is_rotate  = (op_q == OP_ROTR) || (op_q == OP_ROTL);
        last_chunk = (idx_q == IW'(N-1));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        amt_d   = amt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.opcode;
                    a_d     = bus.A_in;
                    amt_d   = bus.B_in[AW-1:0];
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (is_rotate) begin
                    res_d   = rot_res;
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_sum;
                    if (last_chunk) begin
                        res_d   = red_res;
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            amt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            amt_q   <= amt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.Alu_out   = res_q;
endmodule

// File: tb/tb_bmi_alu_seq.sv
// Directed bench for bmi_alu_seq at default width plus a 64/16 instance.
module tb_bmi_alu_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bmi_alu_seq_if #(.DATA_WIDTH(256)) bus ();
    bmi_alu_seq_if #(.DATA_WIDTH(64))  bus64 ();

    bmi_alu_seq #(.DATA_WIDTH(256), .CHUNK_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    bmi_alu_seq #(.DATA_WIDTH(64), .CHUNK_WIDTH(16)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the 256-bit unit, then check latency and result.
    task automatic run256(input string tag, input logic [1:0] op, input logic [255:0] a,
                          input logic [255:0] b, input logic [255:0] exp, input int exp_lat);
        int lat;
        chk({tag, "_in_ready"}, 256'(bus.in_ready), 256'(1));
        bus.in_valid  = 1'b1;
        bus.opcode    = op;
        bus.A_in      = a;
        bus.B_in      = b;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.A_in     = {8{$urandom()}};
        bus.B_in     = {8{$urandom()}};
        bus.opcode   = 2'(~op);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 256'(lat), 256'(exp_lat));
        chk({tag, "_result"}, bus.Alu_out, exp);
        $display("op=%0d tag=%s latency=%0d result=%h", op, tag, lat, bus.Alu_out);
        step();
        chk({tag, "_back_idle"}, 256'({bus.in_ready, bus.out_valid}), 256'(2'b10));
    endtask

    task automatic run64(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        bus64.in_valid  = 1'b1;
        bus64.opcode    = op;
        bus64.A_in      = a;
        bus64.B_in      = b;
        bus64.out_ready = 1'b1;
        step();
        bus64.in_valid = 1'b0;
        bus64.A_in     = {2{$urandom()}};
        lat = 0;
        while (!bus64.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 256'(lat), 256'(exp_lat));
        chk({tag, "_result"}, 256'(bus64.Alu_out), 256'(exp));
        $display("w64 op=%0d tag=%s latency=%0d result=%h", op, tag, lat, bus64.Alu_out);
        step();
    endtask

    initial begin
        logic [255:0] held;
        bit           saw_valid;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.opcode = 2'b00; bus.A_in = '0; bus.B_in = '0; bus.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.opcode = 2'b00; bus64.A_in = '0; bus64.B_in = '0;
        bus64.out_ready = 1'b0;
        step();
        // Request coincident with reset must not be accepted.
        bus.in_valid = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("reset_flags", 256'({bus.in_ready, bus.out_valid, bus.busy}), 256'(3'b100));
        chk("reset_alu_out", bus.Alu_out, '0);

        run256("rotr_1", 2'b01, 256'd1, 256'd1, {1'b1, 255'b0}, 1);
        run256("rotl_257", 2'b10, {1'b1, 255'b0}, 256'd257, 256'd1, 1);
        run256("rotl_0", 2'b10, 256'h1234, 256'd0, 256'h1234, 1);
        run256("pop_ones", 2'b11, {256{1'b1}}, 256'd0, 256'd256, 8);
        run256("pop_zero", 2'b11, 256'd0, 256'd0, 256'd0, 8);
        run256("pop_f0f0", 2'b11, 256'hF0F0, 256'd0, 256'd8, 8);
        run256("par_7", 2'b00, 256'h7, 256'd0, 256'd1, 8);
        run256("par_3", 2'b00, 256'h3, 256'd0, 256'd0, 8);
        run256("par_msb", 2'b00, {1'b1, 255'b0}, 256'd0, 256'd1, 8);

        // Backpressure: hold the result in DONE while the request side churns.
        bus.in_valid  = 1'b1;
        bus.opcode    = 2'b11;
        bus.A_in      = 256'hFF;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("bp_out_valid", 256'(bus.out_valid), 256'(1));
        chk("bp_result", bus.Alu_out, 256'd8);
        held = bus.Alu_out;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.opcode   = 2'(i);
            bus.A_in     = {8{$urandom()}};
            step();
            chk("bp_hold_flags", 256'({bus.out_valid, bus.in_ready, bus.busy}), 256'(3'b101));
            chk("bp_hold_data", bus.Alu_out, held);
        end
        // Consume with in_valid still high: the consuming edge must not accept.
        bus.in_valid  = 1'b1;
        bus.opcode    = 2'b01;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("bp_release_flags", 256'({bus.in_ready, bus.out_valid, bus.busy}), 256'(3'b100));
        chk("bp_release_data", bus.Alu_out, held);
        run256("after_bp", 2'b01, 256'h10, 256'd4, 256'h1, 1);

        // Reset mid-reduction aborts the operation and clears the result.
        bus.in_valid = 1'b1;
        bus.opcode   = 2'b11;
        bus.A_in     = 256'hFFFF;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_mid_flags", 256'({bus.in_ready, bus.out_valid, bus.busy}), 256'(3'b100));
        chk("rst_mid_alu_out", bus.Alu_out, '0);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid) saw_valid = 1'b1;
        end
        chk("rst_no_valid", 256'(saw_valid), 256'(0));

        run64("w64_pop", 2'b11, 64'hFFFF_0000_FFFF_0000, 64'd0, 64'd32, 4);
        run64("w64_rotr4", 2'b01, 64'h1, 64'd4, 64'h1000_0000_0000_0000, 1);
        run64("w64_rotl68", 2'b10, 64'h1, 64'd68, 64'h10, 1);
        run64("w64_par", 2'b00, 64'h8000_0000_0000_0000, 64'd0, 64'd1, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
